// File: rtl/fire_sequencer_if.sv
// Channel-side strobe and flag bundle between the fire sequencer (master)
// and a bank of NCH transducer output channels (slave).
interface fire_sequencer_if #(
  parameter int NCH = 8
);
  logic           chan_rst;
  logic           mark;
  logic           go;
  logic [NCH-1:0] fire_complete_in;
  logic [NCH-1:0] warning_in;

  modport master (output chan_rst, mark, go, input  fire_complete_in, warning_in);
  modport slave  (input  chan_rst, mark, go, output fire_complete_in, warning_in);
endinterface

// File: rtl/fire_sequencer.sv
// Transmit-shot initiator: sequences channel reset, arm (mark) and fire (go)
// strobes across NCH channels and reports done / timeout / fault to the host.
module fire_sequencer #(
  parameter int NCH     = 8,
  parameter int TO_W    = 16,
  parameter int RST_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ready,
  input  logic [NCH-1:0]   chan_en,
  input  logic [TO_W-1:0]  timeout_cycles,
  input  logic             fault_clr,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             fault,
  output logic [NCH-1:0]   fault_chan,
  output logic [15:0]      shot_count,
  fire_sequencer_if.master chanBus
);

  localparam int              RC_W     = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [RC_W-1:0] RST_LAST = RC_W'(RST_CYC - 1);

  typedef enum logic [2:0] {PRE_RST, IDLE, ARM, FIRE, POST_RST} stateT;

  stateT           state, nextState;
  logic [RC_W-1:0] rstCnt;
  logic [TO_W-1:0] phaseCnt, toQ;
  logic [NCH-1:0]  enQ, warnBits, doneBits;
  logic            donePending, warnHit, rstDone, phaseLimit;
  logic            armClear, fireDone, accept;

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    warnBits         = chanBus.warning_in & enQ;
    doneBits         = chanBus.fire_complete_in & enQ;
    warnHit          = |warnBits;
    armClear         = (doneBits == '0);
    fireDone         = (doneBits == enQ);
    rstDone          = (rstCnt == RST_LAST);
    // The limit is hit on the to_q-th cycle of a phase.
    phaseLimit       = (toQ != '0) && (phaseCnt == toQ - 1'b1);
    ready            = (state == IDLE) && !timeout && !fault;
    accept           = start && ready;
    busy             = (state != IDLE);
    chanBus.mark     = (state == ARM) || (state == FIRE);
    chanBus.go       = (state == FIRE);
    chanBus.chan_rst = (state == PRE_RST) || (state == POST_RST);
    nextState        = state;
    unique case (state)
      PRE_RST:  if (rstDone) nextState = IDLE;
      IDLE:     if (accept) nextState = (chan_en == '0) ? POST_RST : ARM;
      ARM: begin
        if (warnHit)         nextState = POST_RST;
        else if (armClear)   nextState = FIRE;
        else if (phaseLimit) nextState = POST_RST;
      end
      FIRE:     if (warnHit || fireDone || phaseLimit) nextState = POST_RST;
      POST_RST: if (rstDone) nextState = IDLE;
      default:  nextState = PRE_RST;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= PRE_RST;
      rstCnt      <= '0;
      phaseCnt    <= '0;
      toQ         <= '0;
      enQ         <= '0;
      donePending <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      fault       <= 1'b0;
      fault_chan  <= '0;
      shot_count  <= '0;
    end else begin
      state    <= nextState;
      // Both counters restart on every state entry.
      rstCnt   <= (nextState != state) ? '0 : rstCnt + 1'b1;
      phaseCnt <= (nextState != state) ? '0 : phaseCnt + 1'b1;
      done     <= 1'b0;

      if (state == IDLE) begin
        if (fault_clr) begin
          timeout    <= 1'b0;
          fault      <= 1'b0;
          fault_chan <= '0;
        end
        if (accept) begin
          enQ         <= chan_en;
          toQ         <= timeout_cycles;
          donePending <= (chan_en == '0);
        end
      end

      if ((state == ARM || state == FIRE || state == POST_RST) && warnHit) begin
        fault      <= 1'b1;
        fault_chan <= fault_chan | warnBits;
      end

      // Priority within a phase: warning, then exit condition, then timeout.
      if (state == ARM || state == FIRE) begin
        if (warnHit) begin
          donePending <= 1'b0;
        end else if (state == FIRE && fireDone) begin
          donePending <= 1'b1;
        end else if (nextState == POST_RST) begin
          timeout     <= 1'b1;
          donePending <= 1'b0;
        end
      end

      if (state == POST_RST && rstDone) begin
        done        <= donePending;
        shot_count  <= shot_count + {15'd0, donePending};
        donePending <= 1'b0;
      end
    end
  end

endmodule
